// File: rtl/hp0_pkg.sv
// AXI3 encodings, writer FSM states and config helpers shared by the HP0 ring writer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package hp0_pkg;

    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [2:0] SIZE_4B      = 3'b010;
    localparam logic [3:0] CACHE_BUFMOD = 4'b0011;
    localparam logic [1:0] RESP_OKAY    = 2'b00;

    // One 16-beat burst of 4-byte words; base and ring size are kept at this granularity.
    localparam logic [31:0] BURST_BYTES = 32'd64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        W    = 2'd2,
        B    = 2'd3
    } wr_state_t;

    // A ring must be non-empty and burst-aligned; the base must be burst-aligned so no
    // burst ever straddles a 4 KB boundary.
    function automatic logic cfg_bad(input logic [31:0] base, input logic [31:0] ring);
        return (base[5:0] != 6'd0) || (ring[5:0] != 6'd0) || (ring == 32'd0);
    endfunction

endpackage

// File: rtl/hp0_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and flush.
// Latency: a pushed word is visible on rd_dat_o one cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored; caller gates with full_o/empty_o.
module hp0_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     wr_vld_i,
    input  logic [WIDTH-1:0]         wr_dat_i,
    input  logic                     rd_rdy_i,
    output logic [WIDTH-1:0]         rd_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             push;
    logic             pop;

    assign full_o   = (count_q == FULL_CNT);
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    assign rd_dat_o = mem_q[rd_ptr_q];
    assign push     = wr_vld_i & ~full_o;
    assign pop      = rd_rdy_i & ~empty_o;

    // Storage array: written on accepted push, never reset (contents are qualified by count).
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/hp0_ring_writer.sv
// Streams input words into a DDR ring over S_AXI_HP0 as 16-beat INCR bursts, one outstanding.
// Latency: burst request 1 cycle after 16 words are buffered; wr_ptr updates 1 cycle after B handshake.
// Backpressure: s_ready drops when the FIFO is full, disabled, or config is bad; AXI valids hold until accepted.
module hp0_ring_writer
    import hp0_pkg::*;
#(
    parameter int         FIFO_DEPTH = 64,
    parameter int         BURST_LEN  = 16,
    parameter logic [5:0] AXI_ID     = 6'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] base_addr,
    input  logic [31:0] ring_bytes,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] S_AXI_HP0_awaddr,
    output logic        S_AXI_HP0_awvalid,
    output logic [3:0]  S_AXI_HP0_awlen,
    output logic [2:0]  S_AXI_HP0_awsize,
    output logic [1:0]  S_AXI_HP0_awburst,
    output logic [3:0]  S_AXI_HP0_awcache,
    output logic [2:0]  S_AXI_HP0_awprot,
    output logic [1:0]  S_AXI_HP0_awlock,
    output logic [3:0]  S_AXI_HP0_awqos,
    output logic [5:0]  S_AXI_HP0_awid,
    input  logic        S_AXI_HP0_awready,
    output logic [31:0] S_AXI_HP0_wdata,
    output logic [3:0]  S_AXI_HP0_wstrb,
    output logic        S_AXI_HP0_wlast,
    output logic        S_AXI_HP0_wvalid,
    output logic [5:0]  S_AXI_HP0_wid,
    input  logic        S_AXI_HP0_wready,
    input  logic        S_AXI_HP0_bvalid,
    input  logic [1:0]  S_AXI_HP0_bresp,
    input  logic [5:0]  S_AXI_HP0_bid,
    output logic        S_AXI_HP0_bready,
    output logic [31:0] wr_ptr,
    output logic        cfg_err,
    output logic        resp_err
);

    localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
    localparam int              BW        = $clog2(BURST_LEN);
    localparam logic [CW-1:0]   BURST_CNT = CW'(BURST_LEN);
    localparam logic [BW-1:0]   LAST_BEAT = BW'(BURST_LEN - 1);

    // Configuration captured on the enable rising edge
    logic        enable_q;
    logic [31:0] base_q;
    logic [31:0] ring_q;
    logic        cfg_err_q;

    // Burst FSM and its registered AXI outputs
    wr_state_t   state_q;
    logic        awvalid_q;
    logic [31:0] awaddr_q;
    logic        wvalid_q;
    logic        wlast_q;
    logic        bready_q;
    logic [BW-1:0] beat_q;
    logic [31:0] offset_q;
    logic [31:0] offset_d;
    logic [31:0] offset_inc;
    logic [31:0] wr_ptr_q;
    logic        resp_err_q;

    // Input buffer
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_flush;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   fifo_dat;
    logic          burst_go;

    // The bid return and the empty flag carry no information this block needs:
    // IDs are constant and a burst only starts once 16 words are already counted.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_HP0_bid, fifo_empty};

    assign s_ready    = enable & ~cfg_err_q & ~fifo_full;
    assign fifo_push  = s_valid & s_ready;
    assign fifo_pop   = wvalid_q & S_AXI_HP0_wready;
    // Only flush between bursts so an in-flight burst always gets its 16 words.
    assign fifo_flush = (state_q == IDLE) & ~enable;

    // enable_q also blocks a start in the rising-edge cycle, before new config is in place.
    assign burst_go   = enable & enable_q & ~cfg_err_q & (fifo_count >= BURST_CNT);

    // Wrap with >= so a ring shrunk by a re-enable mid-run still lands back at 0.
    assign offset_inc = offset_q + BURST_BYTES;
    assign offset_d   = (offset_inc >= ring_q) ? 32'd0 : offset_inc;

    hp0_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush_i  (fifo_flush),
        .wr_vld_i (fifo_push),
        .wr_dat_i (s_data),
        .rd_rdy_i (fifo_pop),
        .rd_dat_o (fifo_dat),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count)
    );

    // Latch ring geometry on enable rising edge; a bad config stays flagged until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q  <= 1'b0;
            base_q    <= '0;
            ring_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            enable_q <= enable;
            if (enable && !enable_q) begin
                base_q <= base_addr;
                ring_q <= ring_bytes;
                if (cfg_bad(base_addr, ring_bytes)) begin
                    cfg_err_q <= 1'b1;
                end
            end
        end
    end

    // Burst sequencer: address, then 16 data beats, then response, one burst at a time.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            awvalid_q  <= 1'b0;
            awaddr_q   <= '0;
            wvalid_q   <= 1'b0;
            wlast_q    <= 1'b0;
            bready_q   <= 1'b0;
            beat_q     <= '0;
            offset_q   <= '0;
            wr_ptr_q   <= '0;
            resp_err_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!enable) begin
                        offset_q <= '0;
                        wr_ptr_q <= '0;
                    end else if (burst_go) begin
                        awaddr_q  <= base_q + offset_q;
                        awvalid_q <= 1'b1;
                        state_q   <= AW;
                    end
                end
                AW: begin
                    if (S_AXI_HP0_awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        beat_q    <= '0;
                        wlast_q   <= (LAST_BEAT == '0);
                        state_q   <= W;
                    end
                end
                W: begin
                    if (S_AXI_HP0_wready) begin
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= B;
                        end else begin
                            beat_q  <= beat_q + 1'b1;
                            wlast_q <= ((beat_q + 1'b1) == LAST_BEAT);
                        end
                    end
                end
                B: begin
                    if (S_AXI_HP0_bvalid) begin
                        bready_q <= 1'b0;
                        if (S_AXI_HP0_bresp != RESP_OKAY) begin
                            resp_err_q <= 1'b1;
                        end
                        offset_q <= offset_d;
                        wr_ptr_q <= offset_d;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign S_AXI_HP0_awaddr  = awaddr_q;
    assign S_AXI_HP0_awvalid = awvalid_q;
    assign S_AXI_HP0_awlen   = 4'(BURST_LEN - 1);
    assign S_AXI_HP0_awsize  = SIZE_4B;
    assign S_AXI_HP0_awburst = BURST_INCR;
    assign S_AXI_HP0_awcache = CACHE_BUFMOD;
    assign S_AXI_HP0_awprot  = 3'b000;
    assign S_AXI_HP0_awlock  = 2'b00;
    assign S_AXI_HP0_awqos   = 4'h0;
    assign S_AXI_HP0_awid    = AXI_ID;
    assign S_AXI_HP0_wdata   = fifo_dat;
    assign S_AXI_HP0_wstrb   = 4'hF;
    assign S_AXI_HP0_wlast   = wlast_q;
    assign S_AXI_HP0_wvalid  = wvalid_q;
    assign S_AXI_HP0_wid     = AXI_ID;
    assign S_AXI_HP0_bready  = bready_q;
    assign wr_ptr            = wr_ptr_q;
    assign cfg_err           = cfg_err_q;
    assign resp_err          = resp_err_q;

endmodule

// File: tb/tb_hp0_ring_writer.sv
// Scoreboard bench for hp0_ring_writer: stimulus queues expected AW/W/B results, a monitor checks them.
// Latency: n/a.
// Backpressure: slave model applies none, random, or held-off wready depending on stall_mode.
module tb_hp0_ring_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] base_addr;
    logic [31:0] ring_bytes;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic [1:0]  awlock;
    logic [3:0]  awqos;
    logic [5:0]  awid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic [5:0]  wid;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic [5:0]  bid;
    logic        bready;
    logic [31:0] wr_ptr;
    logic        cfg_err;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_w[$];
    logic [31:0] exp_aw[$];
    logic [31:0] exp_ptr[$];

    int          stall_mode = 0;
    logic [1:0]  bresp_next = 2'b00;
    int          b_pend = 0;
    logic        ptr_chk = 1'b0;
    int          mon_beat = 0;

    always #5 clk = ~clk;

    hp0_ring_writer dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .base_addr         (base_addr),
        .ring_bytes        (ring_bytes),
        .s_data            (s_data),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .S_AXI_HP0_awaddr  (awaddr),
        .S_AXI_HP0_awvalid (awvalid),
        .S_AXI_HP0_awlen   (awlen),
        .S_AXI_HP0_awsize  (awsize),
        .S_AXI_HP0_awburst (awburst),
        .S_AXI_HP0_awcache (awcache),
        .S_AXI_HP0_awprot  (awprot),
        .S_AXI_HP0_awlock  (awlock),
        .S_AXI_HP0_awqos   (awqos),
        .S_AXI_HP0_awid    (awid),
        .S_AXI_HP0_awready (awready),
        .S_AXI_HP0_wdata   (wdata),
        .S_AXI_HP0_wstrb   (wstrb),
        .S_AXI_HP0_wlast   (wlast),
        .S_AXI_HP0_wvalid  (wvalid),
        .S_AXI_HP0_wid     (wid),
        .S_AXI_HP0_wready  (wready),
        .S_AXI_HP0_bvalid  (bvalid),
        .S_AXI_HP0_bresp   (bresp),
        .S_AXI_HP0_bid     (bid),
        .S_AXI_HP0_bready  (bready),
        .wr_ptr            (wr_ptr),
        .cfg_err           (cfg_err),
        .resp_err          (resp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // All bench inputs change at negedge+1; the monitor samples at negedge+2.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input int gap);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        #1;
        while (!s_ready && n < 2000) begin
            step();
            #1;
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=s_ready_low required=accept data=%h", d);
        end else begin
            exp_w.push_back(d);
        end
        step();
        s_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic wait_drain(input int keep, input string name);
        int n;
        n = 0;
        while (!(exp_aw.size() == 0 && exp_ptr.size() == 0 && exp_w.size() == keep &&
                 !ptr_chk && b_pend == 0 && !bvalid) && n < 20000) begin
            step();
            n++;
        end
        checks++;
        if (n >= 20000) begin
            errors++;
            $display("FAIL %s drain actual aw=%0d w=%0d ptr=%0d required aw=0 w=%0d ptr=0",
                     name, exp_aw.size(), exp_w.size(), exp_ptr.size(), keep);
        end
        repeat (2) step();
    endtask

    task automatic disable_run();
        enable = 1'b0;
        repeat (3) step();
    endtask

    // AXI slave: ready generation and B responses, one per completed last beat.
    initial begin : slave
        logic hs_wlast;
        logic hs_b;
        hs_wlast = 1'b0;
        hs_b     = 1'b0;
        awready  = 1'b0;
        wready   = 1'b0;
        bvalid   = 1'b0;
        bresp    = 2'b00;
        bid      = 6'd0;
        forever begin
            step();
            if (reset) begin
                b_pend   = 0;
                bvalid   = 1'b0;
                hs_wlast = 1'b0;
                hs_b     = 1'b0;
            end else begin
                if (hs_wlast) b_pend++;
                if (hs_b) begin
                    bvalid = 1'b0;
                    b_pend--;
                end
                case (stall_mode)
                    1: begin
                        awready = 1'($urandom_range(0, 1));
                        wready  = 1'($urandom_range(0, 1));
                    end
                    2: begin
                        awready = 1'b1;
                        wready  = 1'b0;
                    end
                    default: begin
                        awready = 1'b1;
                        wready  = 1'b1;
                    end
                endcase
                if (!bvalid && b_pend > 0 && (stall_mode != 1 || $urandom_range(0, 1) == 1)) begin
                    bvalid = 1'b1;
                    bresp  = bresp_next;
                end
                hs_wlast = wvalid & wready & wlast;
                hs_b     = bvalid & bready;
            end
        end
    end

    // Monitor: compares every AXI handshake with the scoreboard queues and checks hold rules.
    initial begin : monitor
        logic        p_awv, p_awr, p_wv, p_wr, p_wl;
        logic [31:0] p_awaddr, p_wdata;
        logic [27:0] attr_exp;
        attr_exp = {4'hF, 3'b010, 2'b01, 4'b0011, 3'b000, 2'b00, 4'h0, 6'd0};
        p_awv = 1'b0; p_awr = 1'b0; p_wv = 1'b0; p_wr = 1'b0; p_wl = 1'b0;
        p_awaddr = '0; p_wdata = '0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                p_awv = 1'b0; p_wv = 1'b0; ptr_chk = 1'b0; mon_beat = 0;
            end else begin
                if (ptr_chk) begin
                    ptr_chk = 1'b0;
                    if (exp_ptr.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wr_ptr_unexpected actual=%h required=no_response", wr_ptr);
                    end else begin
                        chk("wr_ptr", wr_ptr, exp_ptr.pop_front());
                    end
                end
                if (p_awv && !p_awr) begin
                    chk("aw_hold_valid", 32'(awvalid), 32'd1);
                    chk("aw_hold_addr", awaddr, p_awaddr);
                end
                if (p_wv && !p_wr) begin
                    chk("w_hold_valid", 32'(wvalid), 32'd1);
                    chk("w_hold_data", wdata, p_wdata);
                    chk("w_hold_last", 32'(wlast), 32'(p_wl));
                end
                if (awvalid) chk("aw_w_overlap", 32'(wvalid), 32'd0);
                if (awvalid && awready) begin
                    chk("aw_attr", 32'({awlen, awsize, awburst, awcache, awprot, awlock, awqos, awid}),
                        32'(attr_exp));
                    if (exp_aw.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL aw_unexpected actual=%h required=no_burst", awaddr);
                    end else begin
                        chk("awaddr", awaddr, exp_aw.pop_front());
                    end
                end
                if (wvalid && wready) begin
                    chk("wlast", 32'(wlast), 32'(mon_beat == 15));
                    chk("wstrb_wid", 32'({wstrb, wid}), 32'h3C0);
                    if (exp_w.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wdata_unexpected actual=%h required=no_beat", wdata);
                    end else begin
                        chk("wdata", wdata, exp_w.pop_front());
                    end
                    mon_beat = (mon_beat == 15) ? 0 : mon_beat + 1;
                end
                if (bvalid && bready) ptr_chk = 1'b1;
                p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
                p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wl = wlast;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish checks=%0d errors=%0d", checks, errors);
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int d;
        int rdy_cnt;
        int n;
        reset = 1'b1; enable = 1'b0; base_addr = '0; ring_bytes = '0;
        s_data = '0; s_valid = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_wvalid", 32'(wvalid), 32'd0);
        chk("rst_bready", 32'(bready), 32'd0);
        chk("rst_wr_ptr", wr_ptr, 32'd0);
        chk("rst_flags", 32'({cfg_err, resp_err}), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);

        // Single burst of words 0..15
        base_addr = 32'h1000_0000; ring_bytes = 32'd256;
        exp_aw.push_back(32'h1000_0000);
        exp_ptr.push_back(32'h40);
        enable = 1'b1;
        for (int i = 0; i < 16; i++) send(32'(i), 0);
        wait_drain(0, "single");
        chk("single_wr_ptr", wr_ptr, 32'h40);
        disable_run();
        chk("disable_wr_ptr", wr_ptr, 32'd0);

        // Five bursts around a 256-byte ring
        exp_aw = '{32'h1000_0000, 32'h1000_0040, 32'h1000_0080, 32'h1000_00C0, 32'h1000_0000};
        exp_ptr = '{32'h40, 32'h80, 32'hC0, 32'h00, 32'h40};
        enable = 1'b1;
        for (int i = 0; i < 80; i++) send(32'h100 + 32'(i), 0);
        wait_drain(0, "wrap");
        disable_run();

        // FIFO fill with wready held low, then release
        base_addr = 32'h3000_0000; ring_bytes = 32'h80;
        exp_aw = '{32'h3000_0000, 32'h3000_0040, 32'h3000_0000, 32'h3000_0040, 32'h3000_0000};
        exp_ptr = '{32'h40, 32'h00, 32'h40, 32'h00, 32'h40};
        stall_mode = 2;
        enable = 1'b1;
        step();
        d = 0;
        for (int c = 0; c < 120; c++) begin
            s_valid = 1'b1;
            s_data  = 32'h5000_0000 + 32'(d);
            #1;
            if (s_ready) begin
                exp_w.push_back(s_data);
                d++;
            end
            step();
        end
        s_valid = 1'b0;
        chk("fill_count", 32'(d), 32'd64);
        chk("fill_s_ready", 32'(s_ready), 32'd0);
        stall_mode = 0;
        for (int i = d; i < 80; i++) send(32'h5000_0000 + 32'(i), 0);
        wait_drain(0, "fill");
        disable_run();

        // Random stalls and gaps; 8 trailing words stay buffered and are flushed
        base_addr = 32'h2000_0100; ring_bytes = 32'h140;
        for (int i = 0; i < 62; i++) begin
            exp_aw.push_back(32'h2000_0100 + 32'((i % 5) * 64));
            exp_ptr.push_back(32'(((i + 1) % 5) * 64));
        end
        stall_mode = 1;
        enable = 1'b1;
        for (int i = 0; i < 1000; i++) send($urandom, $urandom_range(0, 2));
        wait_drain(8, "random");
        stall_mode = 0;
        disable_run();
        chk("random_leftover", 32'(exp_w.size()), 32'd8);
        exp_w.delete();

        // Enable dropped during beat 7: burst completes, then flush and pointer clear
        base_addr = 32'h1000_0000; ring_bytes = 32'd256;
        exp_aw.push_back(32'h1000_0000);
        exp_ptr.push_back(32'h40);
        enable = 1'b1;
        for (int i = 0; i < 20; i++) send(32'hA000 + 32'(i), 0);
        n = 0;
        while (mon_beat != 7 && n < 500) begin
            step();
            n++;
        end
        chk("drop_reached_beat7", 32'(mon_beat), 32'd7);
        enable = 1'b0;
        wait_drain(4, "drop");
        chk("drop_wr_ptr", wr_ptr, 32'd0);
        chk("drop_s_ready", 32'(s_ready), 32'd0);
        chk("drop_leftover", 32'(exp_w.size()), 32'd4);
        exp_w.delete();

        // Error response: flag set, pointer still advances
        bresp_next = 2'b10;
        exp_aw.push_back(32'h1000_0000);
        exp_ptr.push_back(32'h40);
        enable = 1'b1;
        for (int i = 0; i < 16; i++) send(32'hB000 + 32'(i), 0);
        wait_drain(0, "resp");
        chk("resp_err_set", 32'(resp_err), 32'd1);
        bresp_next = 2'b00;
        disable_run();
        chk("resp_err_sticky", 32'(resp_err), 32'd1);

        // Bad ring size: flagged, input blocked, no bursts
        ring_bytes = 32'd100;
        enable = 1'b1;
        repeat (2) step();
        chk("cfg_err_ring100", 32'(cfg_err), 32'd1);
        rdy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            s_valid = 1'b1;
            s_data  = 32'hDEAD_0000 + 32'(c);
            #1;
            if (s_ready) rdy_cnt++;
            step();
        end
        s_valid = 1'b0;
        chk("cfg_err_s_ready_cycles", 32'(rdy_cnt), 32'd0);
        chk("cfg_err_awvalid", 32'(awvalid), 32'd0);
        enable = 1'b0;

        // Reset clears sticky flags; misaligned base is also rejected
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();
        chk("reset_clears_flags", 32'({cfg_err, resp_err}), 32'd0);
        base_addr = 32'h1000_0020; ring_bytes = 32'd256;
        enable = 1'b1;
        repeat (2) step();
        chk("cfg_err_base_misaligned", 32'(cfg_err), 32'd1);
        chk("cfg_err_misaligned_s_ready", 32'(s_ready), 32'd0);
        enable = 1'b0;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
